cp0: RTL
========

Name: cp0

Overview:
- Coprocessor-0 for the pipelined MIPS core. It is the consumer of the exception and CP0 control signals produced by instruction decode: RI, Ov, AdEL/AdES, syscall, CP0 write, EXL clear, and delay-slot flag.
- Holds SR, Cause, EPC and PRId, and arbitrates interrupts against exceptions.
- Issues the single flush/redirect request to the pipeline.
- Sits at the M stage, next to the bridge, and sees the "macro PC" of the instruction in M.

Parameters:
- PRID, 32'h2024_0701, read-only value of register 15.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address driven on handler_pc.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  mtc0 write strobe (M stage).
- cp0_addr  in  5  register select for read/write (rd field).
- cp0_wdata  in  32  mtc0 data (rt, forwarded).
- cp0_rdata  out  32  mfc0 read data, combinational.
- vpc  in  32  PC of the instruction in M; equals the bubble's inherited PC when M holds a bubble.
- bd_in  in  1  M instruction is in a branch/jump delay slot.
- exc_code_in  in  5  pending exception code from the M instruction; 0 means none.
- hw_int  in  6  external interrupt lines: timer0, timer1, interrupt generator, ...
- exl_clr  in  1  eret in M.
- req  out  1  take exception/interrupt this cycle; flushes F/D/E/M and redirects the PC.
- epc_out  out  32  current EPC, for eret.
- handler_pc  out  32  constant HANDLER_PC.

Behaviour:
- Registers are reset asynchronously to 0: SR, Cause, EPC (and Count/Compare when the timer is enabled). PRId is a constant.
- SR (12): IM=[15:10], EXL=[1], IE=[0]. All other bits read 0.
- Cause (13): BD=[31], IP=[15:10], ExcCode=[6:2]. All other bits read 0. Cause is not writable by mtc0.
- EPC (14): 32-bit, always stored word-aligned (bits [1:0] forced to 0).
- Reads:
  - cp0_rdata selects the register by cp0_addr.
  - Unimplemented addresses read 32'h0.
  - Reads are combinational and see the pre-edge value, with no write-through.
- Interrupt pending: int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- Exception pending: exc_req = (exc_code_in != 0) & ~SR.EXL.
- req = int_req | exc_req, combinational. Interrupt has priority over exception.
- Cause.IP <= hw_int on every clock edge, unconditionally, including while EXL=1.
- On an edge with req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_req ? 0 : exc_code_in.
  - Cause.BD <= bd_in.
  - EPC <= bd_in ? {vpc[31:2],2'b0} - 4 : {vpc[31:2],2'b0}.
- Else if exl_clr: SR.EXL <= 0.
- Else if en: write the register selected by cp0_addr.
  - SR: only IM, EXL, IE are written.
  - EPC: written, aligned.
  - Other addresses are ignored.
- Simultaneous events:
  - req overrides both en and exl_clr; the mtc0/eret instruction is flushed and retried after the handler.
  - en and exl_clr cannot coexist (one instruction).
- Exception codes used: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
- Latency:
  - req is same-cycle.
  - State update is visible one cycle later.
  - epc_out is registered-value only; the pipeline stalls an eret that directly follows an mtc0 to EPC.
- Reset mid-operation: all state clears immediately and req deasserts. Pending hw_int is re-sampled into IP on the first edge after reset release.

Optional Feature:
- Macro CP0_TIMER_EN adds Count (9) and Compare (11).
- Count increments every cycle and wraps at 2^32.
- mtc0 to Count or Compare loads it; a write to Compare also clears the timer pending flag.
- The pending flag is set when Count == Compare after the increment, and is OR'd into hw_int bit 5 for both IP and int_req.
- Without the macro, addresses 9 and 11 read 0, writes are ignored, and hw_int[5] is used as-is.

Decomposition:
- A shared package/header holds:
  - CP0 register addresses 9/11/12/13/14/15;
  - ExcCode constants;
  - SR/Cause bit-position constants;
  - HANDLER_PC default.
- No sub-module except an optional cp0_timer (Count/Compare, pending flag) instantiated under CP0_TIMER_EN.

Test Plan:
- Reset mid-run with EXL=1 and EPC=0x3000 → on assert, SR=Cause=EPC=0 and req=0.
- mtc0 SR=0x0000_FC01, then hw_int=6'b000100 → req=1 same cycle; next cycle Cause=0x0000_1000 (IP[12] set, ExcCode=0), EXL=1, EPC=vpc.
- exc_code_in=10 (RI), bd_in=1, vpc=0x3010 → req=1; then EPC=0x300C, Cause=0x8000_0028, EXL=1.
- EXL=1 with exc_code_in=12 and hw_int=6'h3F → req=0 and EPC unchanged; IP tracks hw_int (Cause[15:10]=6'h3F).
- Same cycle: en=1 writing EPC=0x5000 and exc_code_in=8, vpc=0x3020 → EPC=0x3020, not 0x5000; exl_clr together with req → EXL stays 1.
- CP0_TIMER_EN: Compare=5, Count=0, IM[15]=1, IE=1 → req asserts when Count reaches 5; writing Compare clears the pending flag and req drops.

Source files
------------

// File: rtl/cp0_pkg.sv
// Purpose: shared CP0 constants (register addresses, ExcCodes, SR/Cause bit positions, defaults).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cp0_pkg;

    // CP0 register numbers (rd field of mfc0/mtc0)
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;

    // Exception codes written into Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // SR / Cause field positions
    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
    localparam logic [31:0] PRID_DEFAULT       = 32'h2024_0701;

    // EPC and PC values are always kept word-aligned
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Purpose: Count/Compare timer with sticky pending flag (only built when CP0_TIMER_EN is defined).
// Latency: Count and pending flag update on each clock edge; outputs are registered.
// Backpressure: none; writes are accepted on the edge they are strobed.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_count_i,
    input  logic        wr_compare_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pend_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pend_q, pend_d;

    // Next state: free-running count, loadable compare, pending set on match after the increment
    always_comb begin
        count_d   = wr_count_i ? wdata_i : count_q + 32'd1;
        compare_d = wr_compare_i ? wdata_i : compare_q;
        pend_d    = pend_q;
        if (wr_compare_i) begin
            pend_d = 1'b0;
        end else if (count_d == compare_q) begin
            pend_d = 1'b1;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/cp0.sv
// Purpose: MIPS coprocessor 0 (SR/Cause/EPC/PRId, interrupt vs exception arbitration); CP0_TIMER_EN adds Count/Compare.
// Latency: req and cp0_rdata are combinational; register updates are visible one cycle later.
// Backpressure: none; req overrides any mtc0/eret in the same cycle, which the pipeline flushes and retries.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID       = PRID_DEFAULT,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;

    logic [5:0]  hw_eff;
    logic        int_req, exc_req, wr_ok;
    logic [31:0] vpc_al, sr_word, cause_word;
    logic [31:0] timer_count, timer_compare;

    // mtc0 only lands when neither an exception nor an eret claims the cycle
    assign wr_ok = en & ~req & ~exl_clr;

`ifdef CP0_TIMER_EN
    logic timer_pend;

    cp0_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .wr_count_i   (wr_ok && (cp0_addr == ADDR_COUNT)),
        .wr_compare_i (wr_ok && (cp0_addr == ADDR_COMPARE)),
        .wdata_i      (cp0_wdata),
        .count_o      (timer_count),
        .compare_o    (timer_compare),
        .pend_o       (timer_pend)
    );

    assign hw_eff = hw_int | {timer_pend, 5'b0};
`else
    assign timer_count   = 32'd0;
    assign timer_compare = 32'd0;
    assign hw_eff        = hw_int;
`endif

    assign int_req = (|(hw_eff & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (exc_code_in != 5'd0) & ~sr_exl_q;
    assign req     = (int_req | exc_req) & ~reset;

    assign vpc_al     = word_align(vpc);
    assign sr_word    = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
    assign cause_word = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};

    assign epc_out    = epc_q;
    assign handler_pc = HANDLER_PC;

    // Next state: IP always tracks the lines; exception entry beats eret beats mtc0
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hw_eff;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (req) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? EXC_INT : exc_code_in;
            cause_bd_d  = bd_in;
            epc_d       = bd_in ? vpc_al - 32'd4 : vpc_al;
        end else if (exl_clr) begin
            sr_exl_d = 1'b0;
        end else if (en) begin
            case (cp0_addr)
                ADDR_SR: begin
                    sr_im_d  = cp0_wdata[SR_IM_LO +: 6];
                    sr_exl_d = cp0_wdata[SR_EXL];
                    sr_ie_d  = cp0_wdata[SR_IE];
                end
                ADDR_EPC: epc_d = word_align(cp0_wdata);
                default: ;
            endcase
        end
    end

    // Architectural register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    // mfc0 read mux, pre-edge values, unimplemented addresses read zero
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            ADDR_COUNT:   cp0_rdata = timer_count;
            ADDR_COMPARE: cp0_rdata = timer_compare;
            ADDR_SR:      cp0_rdata = sr_word;
            ADDR_CAUSE:   cp0_rdata = cause_word;
            ADDR_EPC:     cp0_rdata = epc_q;
            ADDR_PRID:    cp0_rdata = PRID;
            default:      cp0_rdata = 32'd0;
        endcase
    end

endmodule
